// File: rtl/timer_pwm_capture.sv
// ============================================================================
// Module   : timer_pwm_capture
// Purpose  : APB timer with prescaler, per-channel input capture, compare
//            toggle and PWM. Optional capture-overrun flags: TIMER_CAPTURE_OVERRUN_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_pwm_capture #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int PRE_WIDTH    = 8
) (
    input  logic                    HCLK,
    input  logic                    RST,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [7:0]              PADDR,
    input  logic [31:0]             PWDATA,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    input  logic [NUM_CHANNELS-1:0] tmr_in,
    output logic [NUM_CHANNELS-1:0] tmr_out,
    output logic [NUM_CHANNELS-1:0] tmr_oe,
    output logic                    IRQ
);

    localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
    localparam logic [7:0] c_ADDR_PERIOD = 8'h04;
    localparam logic [7:0] c_ADDR_CNT    = 8'h08;
    localparam logic [7:0] c_ADDR_FLAGS  = 8'h0C;
    localparam logic [7:0] c_ADDR_IE     = 8'h10;
    localparam logic [7:0] c_ADDR_MODE   = 8'h14;
    localparam logic [7:0] c_ADDR_CCR0   = 8'h20;

    logic                      r_en;
    logic [PRE_WIDTH-1:0]      r_pre;
    logic [PRE_WIDTH-1:0]      r_pre_cnt;
    logic [CNT_WIDTH-1:0]      r_period;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [16:0]               r_flags;
    logic [16:0]               r_ie;
    logic [2*NUM_CHANNELS-1:0] r_mode;
    logic [NUM_CHANNELS-1:0]   r_sync1;
    logic [NUM_CHANNELS-1:0]   r_sync2;
    logic [NUM_CHANNELS-1:0]   r_sync3;
    logic                      r_irq;

    logic                      w_wr;
    logic                      w_wr_cnt;
    logic                      w_tick;
    logic                      w_tick_eff;
    logic                      w_wrap;
    logic [NUM_CHANNELS-1:0]   w_capture;
    logic [NUM_CHANNELS-1:0]   w_match;
    logic [16:0]               w_flag_set;
    logic [16:0]               w_flag_clr;
    logic [CNT_WIDTH-1:0]      w_ccr [NUM_CHANNELS];
    logic                      w_unused;

    assign PREADY     = 1'b1;
    assign IRQ        = r_irq;
    assign w_unused   = ^PWDATA;
    assign w_wr       = PSEL & PENABLE & PWRITE;
    assign w_wr_cnt   = w_wr && (PADDR == c_ADDR_CNT);
    // Prescaler terminal count; >= keeps it sane if PRE shrinks mid-count
    assign w_tick     = r_en && (r_pre_cnt >= r_pre);
    assign w_tick_eff = w_tick && !w_wr_cnt;
    assign w_wrap     = w_tick_eff && (r_cnt == r_period);
    assign w_flag_clr = (w_wr && (PADDR == c_ADDR_FLAGS)) ? PWDATA[16:0] : 17'd0;

    always_ff @(posedge HCLK) begin
        if (RST) begin
            r_en      <= 1'b0;
            r_pre     <= '0;
            r_pre_cnt <= '0;
            r_period  <= '1;
            r_cnt     <= '0;
            r_flags   <= '0;
            r_ie      <= '0;
            r_mode    <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_sync1 <= tmr_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_irq   <= |(r_flags & r_ie);
            r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;

            if (!r_en || w_wr_cnt || w_tick) r_pre_cnt <= '0;
            else                             r_pre_cnt <= r_pre_cnt + 1'b1;

            if (w_wr_cnt)        r_cnt <= PWDATA[CNT_WIDTH-1:0];
            else if (w_tick_eff) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;

            if (w_wr) begin
                case (PADDR)
                    c_ADDR_CTRL: begin
                        r_en  <= PWDATA[0];
                        r_pre <= PWDATA[8 +: PRE_WIDTH];
                    end
                    c_ADDR_PERIOD: r_period <= PWDATA[CNT_WIDTH-1:0];
                    c_ADDR_IE:     r_ie     <= PWDATA[16:0];
                    c_ADDR_MODE:   r_mode   <= PWDATA[2*NUM_CHANNELS-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_flag_set                    = '0;
        w_flag_set[NUM_CHANNELS-1:0]  = w_capture | w_match;
`ifdef TIMER_CAPTURE_OVERRUN_EN
        w_flag_set[8 +: NUM_CHANNELS] = w_capture & r_flags[NUM_CHANNELS-1:0];
`endif
        w_flag_set[16]                = w_wrap;
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [1:0]           w_mode;
        logic [CNT_WIDTH-1:0] r_ccr;
        logic                 r_out;

        assign w_mode       = r_mode[2*i +: 2];
        assign w_capture[i] = (w_mode == 2'b01) && r_sync2[i] && !r_sync3[i];
        assign w_match[i]   = w_tick_eff && w_mode[1] && (r_cnt == r_ccr);
        assign w_ccr[i]     = r_ccr;
        assign tmr_out[i]   = r_out;
        assign tmr_oe[i]    = w_mode[1];

        always_ff @(posedge HCLK) begin
            if (RST) begin
                r_ccr <= '0;
                r_out <= 1'b0;
            end else begin
                // Capture owns CCR; software writes are dropped in capture mode
                if (w_capture[i])
                    r_ccr <= r_cnt;
                else if (w_wr && (PADDR == c_ADDR_CCR0 + 8'(4*i)) && (w_mode != 2'b01))
                    r_ccr <= PWDATA[CNT_WIDTH-1:0];

                case (w_mode)
                    2'b10:   if (w_match[i]) r_out <= ~r_out;
                    2'b11:   r_out <= r_en && (r_cnt < r_ccr);
                    default: r_out <= 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (PADDR)
                c_ADDR_CTRL: begin
                    PRDATA[0]              = r_en;
                    PRDATA[8 +: PRE_WIDTH] = r_pre;
                end
                c_ADDR_PERIOD: PRDATA = 32'(r_period);
                c_ADDR_CNT:    PRDATA = 32'(r_cnt);
                c_ADDR_FLAGS:  PRDATA = 32'(r_flags);
                c_ADDR_IE:     PRDATA = 32'(r_ie);
                c_ADDR_MODE:   PRDATA = 32'(r_mode);
                default: begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (PADDR == c_ADDR_CCR0 + 8'(4*i)) PRDATA = 32'(w_ccr[i]);
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_pwm_capture.sv
// ============================================================================
// Module   : tb_timer_pwm_capture
// Purpose  : Scoreboard bench for timer_pwm_capture (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_pwm_capture;

    logic        HCLK = 1'b0;
    logic        RST;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [3:0]  tmr_in, tmr_out, tmr_oe;
    logic        IRQ;

    timer_pwm_capture dut (
        .HCLK(HCLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .tmr_in(tmr_in), .tmr_out(tmr_out), .tmr_oe(tmr_oe), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        obs_stb = 1'b0;
    logic [31:0] mon_act;
    logic        mon_hit;
    exp_t        mon_e;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Monitor: an APB read access or an observation strobe presents an output
    always @(negedge HCLK) begin
        mon_hit = 1'b0;
        mon_act = 32'd0;
        if (PSEL && PENABLE && !PWRITE) begin
            mon_act = PRDATA;
            mon_hit = 1'b1;
        end else if (obs_stb) begin
            mon_act = {23'd0, IRQ, tmr_oe, tmr_out};
            mon_hit = 1'b1;
        end
        if (mon_hit) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got %h want <none>", mon_act);
            end else begin
                mon_e = sb.pop_front();
                if (mon_act !== mon_e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] e);
        exp_t t;
        t.name = nm;
        t.exp  = e;
        sb.push_back(t);
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        push_exp(nm, e);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Observe {IRQ, tmr_oe, tmr_out} in the current cycle, return one cycle later
    task automatic obs(input logic [31:0] e, input string nm);
        push_exp(nm, e);
        obs_stb = 1'b1;
        @(posedge HCLK); #1 obs_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int          c0, d0;
        logic [31:0] ovr;
`ifdef TIMER_CAPTURE_OVERRUN_EN
        ovr = 32'h200;
`else
        ovr = 32'h0;
`endif
        RST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; tmr_in = '0;
        idle(3);
        RST = 1'b0;

        // Reset state
        apb_rd(8'h00, 32'h0,     "rst_ctrl");
        apb_rd(8'h04, 32'hFFFF,  "rst_period");
        apb_rd(8'h08, 32'h0,     "rst_cnt");
        apb_rd(8'h0C, 32'h0,     "rst_flags");
        apb_rd(8'h14, 32'h0,     "rst_mode");
        apb_rd(8'h20, 32'h0,     "rst_ccr0");
        apb_rd(8'h18, 32'h0,     "unmapped_rd");
        obs(32'h0, "rst_outs");

        // Prescaler 3, period 4: one step every 4 cycles, wrap sets OVF
        apb_wr(8'h04, 32'd4);
        apb_wr(8'h00, 32'h0000_0301);
        for (int i = 0; i < 6; i++) begin
            apb_rd(8'h08, (i == 5) ? 32'd0 : 32'(i), "cnt_seq");
            idle(2);
        end
        apb_rd(8'h0C, 32'h10000, "ovf_flag");
        apb_wr(8'h00, 32'h0);
        apb_wr(8'h0C, 32'h10000);
        apb_rd(8'h0C, 32'h0, "ovf_clear");

        // PWM on ch0: period 9, CCR0 3 -> high for 3 of every 10 ticks
        apb_wr(8'h08, 32'd0);
        apb_wr(8'h04, 32'd9);
        apb_wr(8'h20, 32'd3);
        apb_wr(8'h14, 32'h3);
        apb_wr(8'h00, 32'h1);
        for (int k = 0; k < 20; k++)
            obs(32'h10 | (((k % 10) >= 1 && (k % 10) <= 3) ? 32'h1 : 32'h0), "pwm_duty");
        apb_wr(8'h20, 32'd0);
        idle(1);
        for (int k = 0; k < 12; k++) obs(32'h10, "pwm_ccr0_zero");
        apb_wr(8'h20, 32'd12);
        idle(1);
        for (int k = 0; k < 12; k++) obs(32'h11, "pwm_ccr_above_period");

        // Capture on ch1 with CNT free-running from 0x50
        apb_wr(8'h00, 32'h0);
        apb_wr(8'h14, 32'h4);
        apb_wr(8'h04, 32'hFFFF);
        apb_wr(8'h0C, 32'h1FFFF);
        apb_wr(8'h10, 32'h2);
        apb_wr(8'h00, 32'h1);
        apb_wr(8'h08, 32'h50);
        c0 = cyc;
        tmr_in[1] = 1'b1;
        for (int k = 0; k < 5; k++) obs((k == 4) ? 32'h100 : 32'h0, "cap_irq");
        apb_rd(8'h24, 32'h52, "cap_ccr1");
        apb_rd(8'h0C, 32'h2,  "cap_flag");
        apb_wr(8'h24, 32'h1234);
        apb_rd(8'h24, 32'h52, "ccr_wr_ignored");

        // Second capture lands in the same cycle as a write-1 clear of FLAGS[1]
        tmr_in[1] = 1'b0;
        idle(4);
        tmr_in[1] = 1'b1;
        d0 = cyc;
        idle(1);
        apb_wr(8'h0C, 32'h2);
        apb_rd(8'h0C, 32'h2 | ovr, "set_beats_clear");
        apb_rd(8'h24, 32'(32'h50 + d0 + 2 - c0), "cap2_ccr1");
        apb_wr(8'h0C, 32'h202);
        apb_rd(8'h0C, 32'h0, "flags_cleared");
        obs(32'h0, "irq_dropped");

        // Reset while counting at CNT=7
        apb_wr(8'h00, 32'h0);
        tmr_in[1] = 1'b0;
        apb_wr(8'h14, 32'h3);
        apb_wr(8'h08, 32'd0);
        apb_wr(8'h04, 32'd20);
        apb_wr(8'h00, 32'h1);
        idle(6);
        obs(32'h11, "pre_reset_outs");
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        obs(32'h0, "mid_reset_outs");
        apb_rd(8'h08, 32'h0,    "mid_reset_cnt");
        apb_rd(8'h04, 32'hFFFF, "mid_reset_period");
        apb_rd(8'h00, 32'h0,    "mid_reset_ctrl");
        apb_rd(8'h10, 32'h0,    "mid_reset_ie");
        apb_rd(8'h0C, 32'h0,    "mid_reset_flags");

        // Compare-toggle on ch0: period 4, CCR0 2
        apb_wr(8'h04, 32'd4);
        apb_wr(8'h20, 32'd2);
        apb_wr(8'h14, 32'h2);
        apb_wr(8'h00, 32'h1);
        for (int k = 0; k < 10; k++)
            obs(32'h10 | ((k >= 3 && k <= 7) ? 32'h1 : 32'h0), "cmp_toggle");
        apb_rd(8'h0C, 32'h10001, "cmp_flags");

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
